// File: rtl/benes_pkg.sv
// Shared constants and types for the 16x16 Benes network and its configuration loader.
package benes_pkg;

  localparam int N_PORTS  = 16;
  localparam int N_STAGES = 7;
  localparam int N_SW     = 8;
  localparam int STG_W    = 3;

  typedef logic [STG_W-1:0] stage_idx_t;
  typedef logic [N_SW-1:0]  sw_set_t;

  typedef enum logic [1:0] {
    IDLE,
    FILLING,
    FULL,
    PENDING
  } cfg_state_t;

endpackage

// File: rtl/benes_cfg_loader_if.sv
// Valid/ready write channel carrying one stage's switch settings per transfer.
interface benes_cfg_loader_if #(
  parameter int STG_W = benes_pkg::STG_W,
  parameter int N_SW  = benes_pkg::N_SW
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [STG_W-1:0] cfg_stage;
  logic [N_SW-1:0]  cfg_set;

  modport master (output cfg_valid, output cfg_stage, output cfg_set, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_stage, input  cfg_set, output cfg_ready);
endinterface

// File: rtl/benes_cfg_bank.sv
// Shadow bank: per-stage setting storage plus a written-stage mask with look-ahead full flag.
module benes_cfg_bank #(
  parameter int N_STAGES = benes_pkg::N_STAGES,
  parameter int N_SW     = benes_pkg::N_SW,
  parameter int STG_W    = benes_pkg::STG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [STG_W-1:0]    wr_stage,
  input  logic [N_SW-1:0]     wr_data,
  input  logic                clr,
  output logic [N_SW-1:0]     shadow [N_STAGES],
  output logic [N_STAGES-1:0] mask_nxt,
  output logic                full_nxt
);

  logic [N_STAGES-1:0] mask;
  logic [N_STAGES-1:0] wr_hit;

  // Mask as it will be after this edge, so a commit can see a same-cycle final write.
  always_comb begin
    wr_hit = '0;
    for (int s = 0; s < N_STAGES; s++) begin
      if (wr_en && (int'(wr_stage) == s)) wr_hit[s] = 1'b1;
    end
    mask_nxt = mask | wr_hit;
    full_nxt = &mask_nxt;
  end

  // NOTE: the shadow array is reset because the loader must never expose stale
  // settings after rst_n; memories without such a contract would normally be left unreset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
      for (int s = 0; s < N_STAGES; s++) shadow[s] <= '0;
    end else begin
      for (int s = 0; s < N_STAGES; s++) begin
        if (wr_hit[s]) shadow[s] <= wr_data;
      end
      mask <= clr ? '0 : mask_nxt;
    end
  end

endmodule

// File: rtl/benes_cfg_loader.sv
// Double-buffered switch configuration for the Benes stages: shadow fills freely,
// active bank swaps only at a frame boundary after a commit of a complete set.
module benes_cfg_loader #(
  parameter int N_STAGES = benes_pkg::N_STAGES,
  parameter int N_SW     = benes_pkg::N_SW,
  parameter int STG_W    = benes_pkg::STG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  benes_cfg_loader_if.slave      cfg,
  input  logic                   commit,
  input  logic                   frame_sync,
  output logic [N_SW-1:0]        switch_set [N_STAGES],
  output logic                   cfg_applied,
  output logic                   cfg_err,
  output logic                   busy
);
  import benes_pkg::*;

  cfg_state_t          state, state_nxt;
  logic                wr_acc, stage_ok, wr_en;
  logic                apply, err_nxt;
  logic [N_SW-1:0]     shadow [N_STAGES];
  logic [N_STAGES-1:0] mask_nxt;
  logic                full_nxt;

  assign busy          = (state == PENDING);
  assign cfg.cfg_ready = !busy;
  assign wr_acc        = cfg.cfg_valid && cfg.cfg_ready;
  assign stage_ok      = int'(cfg.cfg_stage) < N_STAGES;
  assign wr_en         = wr_acc && stage_ok;

  benes_cfg_bank #(
    .N_STAGES (N_STAGES),
    .N_SW     (N_SW),
    .STG_W    (STG_W)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_stage (cfg.cfg_stage),
    .wr_data  (cfg.cfg_set),
    .clr      (apply),
    .shadow   (shadow),
    .mask_nxt (mask_nxt),
    .full_nxt (full_nxt)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    apply     = 1'b0;
    err_nxt   = wr_acc && !stage_ok;
    case (state)
      PENDING: begin
        if (frame_sync) begin
          apply     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        if (commit && full_nxt) begin
          state_nxt = PENDING;
        end else begin
          if (commit) err_nxt = 1'b1;
          if (full_nxt)       state_nxt = FULL;
          else if (|mask_nxt) state_nxt = FILLING;
          else                state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cfg_err     <= 1'b0;
      cfg_applied <= 1'b0;
      for (int s = 0; s < N_STAGES; s++) switch_set[s] <= '0;
    end else begin
      state       <= state_nxt;
      cfg_err     <= err_nxt;
      cfg_applied <= apply;
      if (apply) begin
        for (int s = 0; s < N_STAGES; s++) switch_set[s] <= shadow[s];
      end
    end
  end

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Directed self-checking bench for benes_cfg_loader.
module tb_benes_cfg_loader;

  logic       clk;
  logic       rst_n;
  logic       commit;
  logic       frame_sync;
  logic [7:0] switch_set [7];
  logic       cfg_applied;
  logic       cfg_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  benes_cfg_loader_if #(.STG_W(3), .N_SW(8)) cfg_bus ();

  benes_cfg_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg         (cfg_bus),
    .commit      (commit),
    .frame_sync  (frame_sync),
    .switch_set  (switch_set),
    .cfg_applied (cfg_applied),
    .cfg_err     (cfg_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] sw_packed();
    logic [55:0] r;
    for (int s = 0; s < 7; s++) r[8*s +: 8] = switch_set[s];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] st, input logic [7:0] d);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_stage = st;
    cfg_bus.cfg_set   = d;
    tick();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n             = 1'b0;
    commit            = 1'b0;
    frame_sync        = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_stage = '0;
    cfg_bus.cfg_set   = '0;
    #12;
    rst_n = 1'b1;

    // Reset and idle
    for (int i = 0; i < 5; i++) tick();
    check("idle_sw",      {8'h0, sw_packed()}, 64'h0);
    check("idle_ready",   cfg_bus.cfg_ready, 1);
    check("idle_busy",    busy, 0);
    check("idle_applied", cfg_applied, 0);
    check("idle_err",     cfg_err, 0);

    // Full load, commit, frame_sync 10 cycles later
    for (int s = 0; s < 7; s++) write(3'(s), 8'(1 << s));
    check("load_err", cfg_err, 0);
    commit = 1'b1; tick(); commit = 1'b0;
    check("pend_busy",  busy, 1);
    check("pend_ready", cfg_bus.cfg_ready, 0);
    for (int i = 0; i < 10; i++) begin
      check("wait_busy",    busy, 1);
      check("wait_sw",      {8'h0, sw_packed()}, 64'h0);
      check("wait_applied", cfg_applied, 0);
      tick();
    end
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    check("apply1_sw",      {8'h0, sw_packed()}, 64'h0040201008040201);
    check("apply1_applied", cfg_applied, 1);
    check("apply1_busy",    busy, 0);
    tick();
    check("apply1_pulse_end", cfg_applied, 0);

    // Incomplete commit, then last write together with commit
    for (int s = 0; s < 6; s++) write(3'(s), 8'(8'hF0 + s));
    commit = 1'b1; tick(); commit = 1'b0;
    check("partial_err",  cfg_err, 1);
    check("partial_busy", busy, 0);
    check("partial_sw",   {8'h0, sw_packed()}, 64'h0040201008040201);
    tick();
    check("partial_err_end", cfg_err, 0);
    commit = 1'b1; write(3'd6, 8'hF6); commit = 1'b0;
    check("same_cycle_busy", busy, 1);
    check("same_cycle_err",  cfg_err, 0);
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    check("apply2_sw", {8'h0, sw_packed()}, 64'h00F6F5F4F3F2F1F0);

    // Out-of-range stage, overwrite, commit with simultaneous frame_sync
    write(3'd7, 8'h77);
    check("bad_stage_err", cfg_err, 1);
    commit = 1'b1; tick(); commit = 1'b0;
    check("bad_stage_mask_err", cfg_err, 1);
    for (int s = 0; s < 7; s++) write(3'(s), (s == 3) ? 8'hAA : 8'(8'h10 + s));
    write(3'd3, 8'h55);
    commit = 1'b1; frame_sync = 1'b1; tick();
    commit = 1'b0; frame_sync = 1'b0;
    check("cf_busy",    busy, 1);
    check("cf_applied", cfg_applied, 0);
    check("cf_sw",      {8'h0, sw_packed()}, 64'h00F6F5F4F3F2F1F0);

    // Writes held off while pending
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_stage = 3'd0;
    cfg_bus.cfg_set   = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_ready", cfg_bus.cfg_ready, 0);
    end
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    check("apply3_sw",      {8'h0, sw_packed()}, 64'h0016151455121110);
    check("apply3_applied", cfg_applied, 1);

    // frame_sync outside PENDING
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    check("idle_fs_applied", cfg_applied, 0);
    check("idle_fs_busy",    busy, 0);
    commit = 1'b1; tick(); commit = 1'b0;
    check("post_apply_mask_err", cfg_err, 1);

    // Asynchronous reset while pending
    for (int s = 0; s < 7; s++) write(3'(s), 8'(8'hC0 + s));
    commit = 1'b1; tick(); commit = 1'b0;
    check("rst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_sw",      {8'h0, sw_packed()}, 64'h0);
    check("rst_busy",    busy, 0);
    check("rst_ready",   cfg_bus.cfg_ready, 1);
    check("rst_applied", cfg_applied, 0);
    check("rst_err",     cfg_err, 0);
    #1;
    rst_n = 1'b1;
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    check("rst_fs_applied", cfg_applied, 0);
    check("rst_fs_sw",      {8'h0, sw_packed()}, 64'h0);
    commit = 1'b1; tick(); commit = 1'b0;
    check("rst_mask_err", cfg_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/benes_cfg_loader.md
# benes_cfg_loader

Configuration loader for the 16x16 Benes network: accepts per-stage switch-setting words over a valid/ready handshake into a shadow bank, then on commit transfers the complete set into an active bank at the next frame boundary. The active bank drives the 8-bit `switch_set` input of each of the 7 stage modules, so routing never changes mid-frame or from a partial configuration.

## Interface
- `N_STAGES`, default 7: number of network stages (2·log2(16)−1).
- `N_SW`, default 8: 2x2 switches per stage, one setting bit each.
- `STG_W`, default 3: width of the stage index.
- `clk` input, 1 bit: single clock; all state on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `cfg_valid` input, 1 bit: cfg word present.
- `cfg_ready` output, 1 bit: loader accepts a cfg word.
- `cfg_stage` input, `STG_W` bits: target stage index.
- `cfg_set` input, `N_SW` bits: switch settings for that stage; bit i drives switch i.
- `commit` input, 1 bit: request transfer of shadow to active.
- `frame_sync` input, 1 bit: frame boundary strobe from the data path.
- `switch_set` output, `N_SW` bits × `N_STAGES` (unpacked): active settings, element s to stage s.
- `cfg_applied` output, 1 bit: one-cycle pulse when a new configuration goes live.
- `cfg_err` output, 1 bit: one-cycle pulse on a rejected write or commit.
- `busy` output, 1 bit: high while a commit is pending.

## Operation
- States: `IDLE` (mask empty), `FILLING` (mask nonzero, not full), `FULL` (all stages written), `PENDING` (commit accepted, waiting for `frame_sync`).
- Write accept = `cfg_valid && cfg_ready`; `cfg_ready` = 1 in all states except `PENDING`.
- Accepted write with `cfg_stage < N_STAGES`: shadow[stage] ← `cfg_set`, mask[stage] ← 1. A repeat write to the same stage overwrites it silently.
- Accepted write with `cfg_stage ≥ N_STAGES`: nothing stored, `cfg_err` pulses.
- Transitions: `IDLE`→`FILLING` on first valid write; `FILLING`→`FULL` when the mask becomes all-ones; `FULL`/`FILLING`→`PENDING` on `commit` with a full mask; `PENDING`→`IDLE` on `frame_sync`.
- `commit` is evaluated against the mask including a same-cycle accepted write, so a write that completes the mask plus `commit` in the same cycle enters `PENDING`.
- `commit` with an incomplete mask: `cfg_err` pulses, state unchanged. `commit` in `PENDING`: ignored, no error.
- `frame_sync` honoured only in `PENDING`; ignored elsewhere. `commit` and `frame_sync` in the same cycle from `FULL`: enter `PENDING`, then wait for the next `frame_sync`.
- On apply: active ← shadow for all stages at once, mask cleared, shadow retained. A new configuration requires all 7 stages to be written again.

## Timing
- Reset values: `switch_set` all 0 (every switch in pass-through), shadow 0, mask 0, state `IDLE`, `cfg_ready`=1, `cfg_applied`=0, `cfg_err`=0, `busy`=0.
- `switch_set` is registered. It updates on the edge where `frame_sync` is sampled in `PENDING`. `cfg_applied` is high for exactly the following cycle, the first cycle the new settings are visible.
- `cfg_err` is registered: high for one cycle after the offending edge.
- `busy` = (state == `PENDING`), registered. `cfg_ready` = !`busy`.
- Asserting `rst_n` mid-operation, including in `PENDING`, discards the shadow and pending commit and returns all outputs to reset values immediately (asynchronous). There is no partial update of `switch_set`.
- Minimum load-to-live time: 7 write cycles + 1 cycle for `PENDING` entry + the wait for `frame_sync`.

## Structure
- Shared package `benes_pkg`: `N_PORTS`=16, `N_STAGES`=7, `N_SW`=8, `STG_W`=3, `stage_idx_t`, `sw_set_t` (`logic [N_SW-1:0]`), `cfg_state_t` enum {`IDLE`, `FILLING`, `FULL`, `PENDING`}.
- One sub-module, `benes_cfg_bank`: holds shadow storage and the written mask, with write port, clear, and mask-full flag. The top level holds the FSM, active registers and pulse outputs.

## Test plan
- Reset, then idle 5 cycles → `switch_set` all 8'h00, `cfg_ready`=1, `busy`=0, no pulses.
- Write stages 0..6 with 8'h01,8'h02,…,8'h40, then `commit`, then `frame_sync` 10 cycles later → `busy` high for the intervening cycles, `switch_set[s]`=1<<s, and `cfg_applied` pulses once in the same cycle the new values appear.
- Write stages 0..5 only, then `commit` → `cfg_err` pulses, state `FILLING`, `switch_set` unchanged; write stage 6, then `commit` → `PENDING`.
- Write to `cfg_stage`=7 → `cfg_err` pulses, mask unchanged. Write stage 3 twice (8'hAA then 8'h55) → after apply, `switch_set[3]`=8'h55.
- In `PENDING`, hold `cfg_valid` → `cfg_ready`=0 and no write taken until after `frame_sync`. Pulse `frame_sync` in `IDLE` → no effect.
- Assert `rst_n` low while in `PENDING` → all outputs return to reset values at once, and a later `frame_sync` produces no `cfg_applied`.
